waveform_generator: RTL and testbench
=====================================

Name: waveform_generator

Overview:
- DDS-style waveform source for the function generator, directly upstream of the amplitude-scaling stage.
- Drives that stage's 8-bit sample input.
- A phase accumulator, stepped by a programmable frequency word, produces one of four waveforms: sawtooth, triangle, square with programmable duty, or LFSR noise.
- Output is unsigned offset-binary (0..255), registered, one sample per enabled clock.

Parameters:
PHASE_W, 16, phase accumulator width in bits (minimum 8); the top 8 bits form the waveform index p.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  sample-rate enable; when 0 all state holds
freq  input  PHASE_W  phase increment per enabled cycle
wave_sel  input  2  00 sawtooth, 01 triangle, 10 square, 11 noise
duty  input  8  square-wave high threshold, compared against p
res_out  output  8  registered waveform sample, unsigned
wrap  output  1  one-cycle pulse: phase accumulator overflowed on the previous enabled edge

Behaviour:
- Reset: on a rising edge with rst_n=0, the block loads:
  - phase_q=0, lfsr_q=8'h01, res_out=8'h00, wrap=0.
  - Reset has priority over en and applies identically mid-operation.
- Enabled edge (rst_n=1, en=1), all updates simultaneous:
  - p = phase_q[PHASE_W-1:PHASE_W-8].
  - res_out <= f(p, lfsr_q, wave_sel, duty), where f uses the pre-update phase_q and lfsr_q.
  - phase_q <= (phase_q + freq) mod 2^PHASE_W.
  - wrap <= carry-out of that addition.
  - lfsr_q <= {lfsr_q[6:0], lfsr_q[7]^lfsr_q[5]^lfsr_q[4]^lfsr_q[3]}.
- Latency: res_out reflects the phase value that was present before the edge, i.e. one cycle behind phase_q.
- Disabled edge (rst_n=1, en=0): phase_q, lfsr_q and res_out hold; wrap <= 0.
- The LFSR steps on every enabled edge regardless of wave_sel. It has maximal period 255 and never reaches 0.
- Waveform functions:
  - Sawtooth: f = p.
  - Triangle: q = {p[6:0],1'b0}; f = q when p[7]=0, else ~q.
    - p=0 -> 0, p=127 -> 254, p=128 -> 255, p=255 -> 1.
    - Peak-to-peak 0..255, no repeated sample at the peak.
  - Square: f = 8'hFF when p < duty, else 8'h00.
    - duty=0 -> constant 0.
    - duty=255 -> high for all p except 255.
    - duty=128 -> 50%.
  - Noise: f = lfsr_q.
- wave_sel, duty and freq changes take effect on the next enabled edge. Phase is not reset, so a waveform switch is phase-continuous.
- freq=0: phase frozen, output constant for sawtooth/triangle/square, wrap never asserts. Noise continues to step.
- Wrap-around: accumulator overflow is modular, with no saturation.
  - Multiple wraps per cycle are impossible, since freq < 2^PHASE_W.
  - freq = 2^(PHASE_W-1) gives a wrap every second enabled edge.
- No combinational path from any input to any output.

Test Plan:
- Reset then en=1, freq=16'h0100, wave_sel=00 -> res_out = 0,1,2,...,255,0 on consecutive edges after the first; wrap high for exactly one cycle, immediately after the edge where res_out becomes 255.
- freq=16'h0100, wave_sel=01 -> one period of 256 samples: 0,2,...,254,255,253,...,3,1, then repeats from 0.
- freq=16'h0100, wave_sel=10, duty=64 -> per 256-cycle period: 64 samples of 8'hFF then 192 of 8'h00; duty=0 -> all 0; duty=255 -> 255 samples 8'hFF, one 8'h00.
- Reset, wave_sel=11, en=1 -> res_out = 01,02,04,08,11,23 on successive enabled edges; over 255 edges no value 00 appears and the sequence repeats at edge 256.
- freq=16'h8000, en toggled 1,0,1,1 -> phase and res_out hold during en=0; wrap pulses only after enabled edges that carry; wrap=0 on the cycle after en=0.
- Mid-waveform rst_n=0 for one edge while en=1 -> next cycle res_out=0, wrap=0, phase_q=0, lfsr_q=01; sequence restarts exactly as after power-on reset.

Source files
------------

// File: rtl/waveform_generator.sv
// DDS-style waveform source: phase accumulator stepped by a frequency word,
// shaped into sawtooth, triangle, square (programmable duty) or LFSR noise.
// Output is unsigned offset-binary and registered. It lags phase by one cycle.
module waveform_generator #(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] freq,
    input  logic [1:0]         wave_sel,
    input  logic [7:0]         duty,
    output logic [7:0]         res_out,
    output logic               wrap
);

    localparam logic [1:0] SEL_SAW = 2'b00;
    localparam logic [1:0] SEL_TRI = 2'b01;
    localparam logic [1:0] SEL_SQR = 2'b10;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [7:0]         res_q, res_d;
    logic               wrap_q, wrap_d;

    logic [7:0]         p;
    logic [7:0]         tri_ramp;
    logic [PHASE_W:0]   sum;

    // Waveform shaping and next-state from the pre-update phase and LFSR
    always_comb begin
        p        = phase_q[PHASE_W-1 -: 8];
        tri_ramp = {p[6:0], 1'b0};
        sum      = {1'b0, phase_q} + {1'b0, freq};

        unique case (wave_sel)
            SEL_SAW: res_d = p;
            // Rising half doubles p, falling half inverts it, so the peak
            // goes 254 -> 255 -> 253 with no repeated sample.
            SEL_TRI: res_d = p[7] ? ~tri_ramp : tri_ramp;
            SEL_SQR: res_d = (p < duty) ? 8'hFF : 8'h00;
            default: res_d = lfsr_q;
        endcase

        phase_d = sum[PHASE_W-1:0];
        wrap_d  = sum[PHASE_W];
        // Taps 8,6,5,4 give the maximal period of 255. Zero is never reached.
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // State update: reset wins, en gates everything, wrap is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            lfsr_q  <= 8'h01;
            res_q   <= 8'h00;
            wrap_q  <= 1'b0;
        end else if (en) begin
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
            res_q   <= res_d;
            wrap_q  <= wrap_d;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign res_out = res_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Directed bench for waveform_generator: sawtooth, triangle, square duties,
// noise sequence, enable gating with half-scale freq, freq=0 and mid-run reset.
module tb_waveform_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] freq;
    logic [1:0]  wave_sel;
    logic [7:0]  duty;
    logic [7:0]  res_out;
    logic        wrap;

    int errors = 0;
    int checks = 0;

    waveform_generator #(.PHASE_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .freq     (freq),
        .wave_sel (wave_sel),
        .duty     (duty),
        .res_out  (res_out),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] m);
        return {m[6:0], ^(m & 8'hB8)};
    endfunction

    initial begin
        logic [7:0] m;
        logic [7:0] exp_tri;
        logic [7:0] noise_first [6];
        int         hi_cnt;

        noise_first[0] = 8'h01; noise_first[1] = 8'h02; noise_first[2] = 8'h04;
        noise_first[3] = 8'h08; noise_first[4] = 8'h11; noise_first[5] = 8'h23;

        rst_n = 1'b0; en = 1'b1; freq = 16'h0100; wave_sel = 2'b00; duty = 8'd0;

        // Reset state
        do_reset();
        chk("reset_res", res_out, 8'h00);
        chk("reset_wrap", {7'd0, wrap}, 8'h00);

        // Sawtooth ramp, wrap on the same cycle res_out reaches 255
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("saw_res", res_out, 8'(i));
            chk("saw_wrap", {7'd0, wrap}, (i == 255) ? 8'h01 : 8'h00);
        end
        tick();
        chk("saw_restart", res_out, 8'h00);
        chk("saw_wrap_end", {7'd0, wrap}, 8'h00);

        // Triangle: 2p rising, 511-2p falling
        do_reset();
        wave_sel = 2'b01;
        for (int i = 0; i < 256; i++) begin
            tick();
            exp_tri = (i < 128) ? 8'(2 * i) : 8'(511 - 2 * i);
            chk("tri_res", res_out, exp_tri);
        end
        tick();
        chk("tri_restart", res_out, 8'h00);

        // Square duty=64, then duty=0 and duty=255
        do_reset();
        wave_sel = 2'b10; duty = 8'd64;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("sq64_res", res_out, (i < 64) ? 8'hFF : 8'h00);
        end
        duty = 8'd0;
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (res_out != 8'h00) hi_cnt++;
        end
        chk("sq0_high_count", 8'(hi_cnt), 8'd0);
        duty = 8'd255;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("sq255_res", res_out, (i == 255) ? 8'h00 : 8'hFF);
        end

        // Noise: known prefix, never zero, period 255
        do_reset();
        wave_sel = 2'b11;
        m = 8'h01;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (i < 6) chk("noise_prefix", res_out, noise_first[i]);
            chk("noise_seq", res_out, m);
            chk("noise_nonzero", {7'd0, res_out == 8'h00}, 8'h00);
            m = lfsr_next(m);
        end
        tick();
        chk("noise_period", res_out, 8'h01);

        // Enable gating at half-scale freq
        do_reset();
        wave_sel = 2'b00; freq = 16'h8000;
        en = 1'b1; tick();
        chk("en1_res", res_out, 8'h00);
        chk("en1_wrap", {7'd0, wrap}, 8'h00);
        en = 1'b0; tick();
        chk("en0_res_hold", res_out, 8'h00);
        chk("en0_wrap", {7'd0, wrap}, 8'h00);
        en = 1'b1; tick();
        chk("en2_res", res_out, 8'h80);
        chk("en2_wrap", {7'd0, wrap}, 8'h01);
        tick();
        chk("en3_res", res_out, 8'h00);
        chk("en3_wrap", {7'd0, wrap}, 8'h00);
        tick();
        en = 1'b0; tick();
        chk("en0b_res_hold", res_out, 8'h80);
        chk("en0b_wrap_clr", {7'd0, wrap}, 8'h00);
        en = 1'b1;

        // freq=0: phase frozen, output constant, no wrap
        do_reset();
        freq = 16'h0000; wave_sel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("f0_res", res_out, 8'h00);
            chk("f0_wrap", {7'd0, wrap}, 8'h00);
        end

        // Mid-run reset with en=1 restarts exactly as from power-on
        do_reset();
        freq = 16'h0100; wave_sel = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_pre_res", res_out, 8'd9);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_rst_res", res_out, 8'h00);
        chk("mid_rst_wrap", {7'd0, wrap}, 8'h00);
        tick(); chk("mid_saw0", res_out, 8'd0);
        tick(); chk("mid_saw1", res_out, 8'd1);
        wave_sel = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); chk("mid_noise0", res_out, 8'h01);
        tick(); chk("mid_noise1", res_out, 8'h02);
        tick(); chk("mid_noise2", res_out, 8'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
